// File: rtl/ecc_scalar_seq.sv
// Sequencer issuing PRE-CAL, DOUBLE/ADD ladder, DIV-INV square-and-multiply and DIV-MUL ops to the point ALU.
// Optional watchdog: define ECC_SCALAR_SEQ_WDOG_EN.
module ecc_scalar_seq #(
  parameter int               SCALAR_W    = 255,
  parameter int               EXP_W       = 255,
  parameter logic [EXP_W-1:0] INV_EXP     = {EXP_W{1'b1}} - EXP_W'(20),
  parameter int               WDOG_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SCALAR_W-1:0] scalar,
  input  logic                alu_ready,
  output logic                alu_valid,
  output logic [1:0]          alu_state,
  output logic                alu_keep_flag,
  output logic                alu_consecutive_flag,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int MAX_W = (SCALAR_W > EXP_W) ? SCALAR_W : EXP_W;
  localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [IDX_W-1:0] S_TOP = IDX_W'(SCALAR_W - 1);
  localparam logic [IDX_W-1:0] E_TOP = IDX_W'(EXP_W - 1);

  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

  typedef enum logic [3:0] {
    IDLE, PRE_ISS, PRE_WAIT, MUL_ISS, MUL_WAIT,
    INV_ISS, INV_WAIT, DMUL_ISS, DMUL_WAIT, DONE
  } state_t;

  state_t              st;
  logic [SCALAR_W-1:0] scalar_r;
  logic [IDX_W-1:0]    idx, idx_m1;

  assign idx_m1 = idx - 1'b1;

`ifdef ECC_SCALAR_SEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;
  assign in_wait = (st == PRE_WAIT) || (st == MUL_WAIT) || (st == INV_WAIT) || (st == DMUL_WAIT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st                   <= IDLE;
      scalar_r             <= '0;
      idx                  <= '0;
      alu_valid            <= 1'b0;
      alu_state            <= 2'd0;
      alu_keep_flag        <= 1'b0;
      alu_consecutive_flag <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      err                  <= 1'b0;
`ifdef ECC_SCALAR_SEQ_WDOG_EN
      wd_cnt               <= '0;
`endif
    end else begin
      alu_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (st)
        IDLE: if (start) begin
          scalar_r  <= scalar;
          busy      <= 1'b1;
          st        <= PRE_ISS;
          alu_valid <= 1'b1;
          alu_state <= 2'd0;
        end
        // ready during an issue cycle is a protocol violation and is dropped
        PRE_ISS:  st <= PRE_WAIT;
        MUL_ISS:  st <= MUL_WAIT;
        INV_ISS:  st <= INV_WAIT;
        DMUL_ISS: st <= DMUL_WAIT;
        PRE_WAIT: if (alu_ready) begin
          st                   <= MUL_ISS;
          idx                  <= S_TOP;
          alu_valid            <= 1'b1;
          alu_state            <= 2'd1;
          alu_consecutive_flag <= scalar_r[SCALAR_W-1];
          alu_keep_flag        <= (S_TOP != '0);
        end
        // flags move only after ready so they hold for the whole chained op
        MUL_WAIT: if (alu_ready) begin
          if (idx != '0) begin
            idx                  <= idx_m1;
            alu_consecutive_flag <= scalar_r[idx_m1];
            alu_keep_flag        <= (idx_m1 != '0);
          end else begin
            st                   <= INV_ISS;
            idx                  <= E_TOP;
            alu_valid            <= 1'b1;
            alu_state            <= 2'd2;
            alu_consecutive_flag <= INV_EXP[EXP_W-1];
            alu_keep_flag        <= (E_TOP != '0);
          end
        end
        INV_WAIT: if (alu_ready) begin
          if (idx != '0) begin
            idx                  <= idx_m1;
            alu_consecutive_flag <= INV_EXP[idx_m1];
            alu_keep_flag        <= (idx_m1 != '0);
          end else begin
            st                   <= DMUL_ISS;
            alu_valid            <= 1'b1;
            alu_state            <= 2'd3;
            alu_consecutive_flag <= 1'b0;
            alu_keep_flag        <= 1'b0;
          end
        end
        DMUL_WAIT: if (alu_ready) begin
          st   <= DONE;
          done <= 1'b1;
          busy <= 1'b0;
        end
        DONE: begin
          st        <= IDLE;
          alu_state <= 2'd0;
        end
        default: st <= IDLE;
      endcase
`ifdef ECC_SCALAR_SEQ_WDOG_EN
      // wd_cnt = cycles elapsed since the last issue or ready, counting that cycle
      if (!in_wait || alu_ready) begin
        wd_cnt <= WD_W'(1);
      end else if (wd_cnt == WD_W'(WDOG_CYCLES - 1)) begin
        st                   <= IDLE;
        busy                 <= 1'b0;
        err                  <= 1'b1;
        idx                  <= '0;
        alu_state            <= 2'd0;
        alu_keep_flag        <= 1'b0;
        alu_consecutive_flag <= 1'b0;
        wd_cnt               <= WD_W'(1);
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
`endif
    end
  end
endmodule

// File: doc/ecc_scalar_seq.md
Name: ecc_scalar_seq

Overview:
- Sequencer directly upstream of the point-arithmetic ALU; it issues every ALU operation for one Ed25519-style scalar multiplication.
- Op order: PRE-CAL once, then DOUBLE(+ADD) for each scalar bit from MSB to LSB, then DIV-INV square-and-multiply over the inversion exponent, then DIV-MUL once.
- Drives the ALU valid/state/keep/consecutive inputs and consumes its ready pulse.
- Constant-time: all SCALAR_W bits are always processed, with no leading-zero skip.

Parameters:
- SCALAR_W, 255, scalar width in bits; ladder iterations = SCALAR_W.
- EXP_W, 255, inversion exponent width.
- INV_EXP, 2^255-21 (0x7FF…FFEB, EXP_W bits), inversion exponent q-2, scanned from MSB.
- WDOG_CYCLES, 64, max cycles between ALU issue/ready events (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- scalar  in  SCALAR_W  scalar k; latched when start is accepted
- alu_ready  in  1  ALU last-cycle-of-operation pulse
- alu_valid  out  1  one-cycle issue strobe to the ALU
- alu_state  out  2  0 PRE-CAL, 1 DOUBLE, 2 DIV-INV, 3 DIV-MUL
- alu_keep_flag  out  1  ALU chains another same-type op without a new valid
- alu_consecutive_flag  out  1  current bit: DOUBLE→ADD, or DIV-INV multiply by Z instead of 1
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- err  out  1  watchdog timeout pulse; tied 0 without the feature

Behaviour:
- Reset (async, rst=1): state IDLE; alu_valid=0, alu_state=0, alu_keep_flag=0, alu_consecutive_flag=0, busy=0, done=0, err=0; scalar register and index cleared.
  - Reset mid-operation abandons the sequence immediately. Nothing is resumed.
- All outputs are registered.
- FSM states: IDLE, PRE_ISS, PRE_WAIT, MUL_ISS, MUL_WAIT, INV_ISS, INV_WAIT, DMUL_ISS, DMUL_WAIT, DONE.
- IDLE → PRE_ISS when start=1: latch scalar, set busy=1.
  - start while busy is ignored.
- *_ISS states last exactly one cycle with alu_valid=1 and alu_state set for that phase. Each then moves to its *_WAIT state.
- Valid is never issued while the ALU may be non-idle:
  - An ISS state is entered only the cycle after an alu_ready at which alu_keep_flag=0.
  - That is the cycle the ALU is back in IDLE.
- PRE_WAIT: on alu_ready → MUL_ISS; idx=SCALAR_W-1.
- MUL_ISS / MUL_WAIT flag outputs:
  - alu_consecutive_flag = scalar_r[idx]
  - alu_keep_flag = (idx!=0)
- MUL_WAIT on alu_ready:
  - idx!=0: idx decrements and both flags update the next cycle. Stay in MUL_WAIT; the ALU self-chains.
  - idx==0: → INV_ISS with idx=EXP_W-1.
- Flags change only in the cycle after alu_ready. They are therefore stable for the ALU's entire operation, including its DOUBLE cycle-9 and DIV-INV cycle-2 decisions.
- INV_ISS / INV_WAIT: same rule as the MUL phase, using INV_EXP[idx]. On the final ready → DMUL_ISS.
- DMUL_ISS / DMUL_WAIT:
  - alu_keep_flag=0, alu_consecutive_flag=0.
  - On alu_ready → DONE.
- DONE (one cycle): done=1, busy=0. Then → IDLE.
- Flags read 0 in IDLE, PRE_*, DMUL_* and DONE.
- Exactly 1+SCALAR_W+EXP_W+1 alu_ready pulses per run; 512 at defaults.
- alu_ready in IDLE or DONE is ignored.
- alu_ready coincident with an ISS cycle is a protocol violation. It is ignored (not counted).
- Index counter: 8 bits for default widths, generally $clog2(max width). No wrap, because the phase exits at idx==0.

Optional Feature:
- Macro ECC_SCALAR_SEQ_WDOG_EN.
- Enabled:
  - A counter clears on every *_ISS cycle and on every alu_ready.
  - In any *_WAIT state, reaching WDOG_CYCLES without alu_ready produces err=1 for one cycle.
  - The FSM then returns to IDLE with busy=0. No done pulse.
- Disabled: no counter; err is constant 0; WAIT states wait indefinitely.

Test Plan:
- Reset then start with scalar=0; ALU model answers every valid/chain in 10 cycles:
  - alu_valid pulses exactly 4 times, with states 0,1,2,3 in order.
  - 512 ready pulses; alu_consecutive_flag=0 throughout MUL.
  - done pulses once; busy low after.
- scalar=1:
  - consecutive_flag=0 for MUL bits 254..1 and 1 for bit 0.
  - keep_flag drops to 0 only on the last MUL op.
  - INV phase consecutive sequence equals the bits of 0x7FF…FFEB, MSB first; the final 8 values are 1,1,1,0,1,0,1,1.
- start pulsed again mid-MUL phase: ignored; scalar register unchanged; result sequence identical to a single run.
- rst asserted asynchronously during INV_WAIT, between clock edges:
  - All outputs are 0 immediately.
  - A new start afterwards runs the full 512-ready sequence.
- alu_ready asserted during IDLE and on an ISS cycle: no state/index change; ready count to done remains 512.
- With ECC_SCALAR_SEQ_WDOG_EN, WDOG_CYCLES=64: withhold ready after DMUL_ISS → err pulses at cycle 64 after issue; busy=0; no done.
